stage3_writeback_forward: RTL and testbench
===========================================

STAGE3_WRITEBACK_FORWARD -- requirements
Module: stage3_writeback_forward

Interface
REQ-001 SHALL have port clk input 1: single rising-edge clock for all state.
REQ-002 SHALL have port rst input 1: reset, synchronous and active-high.
REQ-003 SHALL have ResultValid input 1 (stage 3 presents a completed result this cycle) and IsLoad input 1 (that result is a load whose data comes from memory).
REQ-004 SHALL have ResultDest input 3 (destination register) and ResultData input 16 (ALU result; ignored when IsLoad=1).
REQ-005 SHALL have MemReady input 1 (memory returns load data) and MemData input 16 (the load data).
REQ-006 SHALL have OD1Read and OD2Read input 1 each (stage 2 operand port reads a register) and OD1Addr, OD2Addr input 3 each.
REQ-007 SHALL have Fwd1Valid output 1 with Fwd1Data output 16, and Fwd2Valid output 1 with Fwd2Data output 16 (bypass values to stage 2).
REQ-008 SHALL have Stall output 1 (freeze stages 1-2) and Busy output 1 (stage 3 must hold its result).
REQ-009 SHALL have WbValid output 1, WbDest output 3 and WbData output 16 (register-file write port).
REQ-010 SHALL have MemTimeout output 1: sticky load-timeout flag.

Function
REQ-011 SHALL keep a 2-entry history: E0 newest, E1 older; each entry holds valid, dest[2:0] and data[15:0].
REQ-012 SHALL implement FSM states IDLE and WAIT_MEM.
REQ-013 In IDLE, ResultValid=1 with IsLoad=0 SHALL, at the next edge, shift E0 into E1 and load {1, ResultDest, ResultData} into E0.
REQ-014 In IDLE, ResultValid=1 with IsLoad=1 SHALL latch ResultDest as PendDest, clear the timeout counter and enter WAIT_MEM; history SHALL stay unchanged.
REQ-015 In WAIT_MEM, MemReady=1 SHALL shift E0 into E1, load {1, PendDest, MemData} into E0 and return to IDLE at the same edge.
REQ-016 Busy SHALL be 1 exactly while in WAIT_MEM; ResultValid is ignored in WAIT_MEM, including when it coincides with MemReady.
REQ-017 WbValid/WbDest/WbData SHALL be registered, asserted for one cycle in the cycle after each E0 load, carrying the values loaded into E0.
REQ-018 Forwarding SHALL be combinational: FwdNValid=1 when ODNRead=1 and a valid entry's dest equals ODNAddr; E0 SHALL take priority over E1; FwdNData SHALL be 0 when FwdNValid=0.
REQ-019 Stall SHALL be combinational: 1 in WAIT_MEM when (OD1Read and OD1Addr==PendDest) or (OD2Read and OD2Addr==PendDest), otherwise 0.
REQ-020 In WAIT_MEM a 4-bit counter SHALL increment each cycle without MemReady; on reaching 15 it SHALL set MemTimeout, load {1, PendDest, 16'h0000} into E0 (with the shift into E1) and return to IDLE.
REQ-021 MemTimeout SHALL remain 1 until rst.
REQ-022 A load targeting a dest already held in E0/E1 SHALL NOT invalidate those entries; Stall alone covers the hazard until the load data arrives.

Reset
REQ-023 rst=1 at a clock edge SHALL force IDLE, clear both entry valids, PendDest=0, counter=0, WbValid=0, WbDest=0, WbData=0 and MemTimeout=0.
REQ-024 rst SHALL take priority over all inputs; a pending load at reset SHALL be dropped with no writeback.
REQ-025 After reset: Fwd*Valid=0, Fwd*Data=0, Stall=0, Busy=0.

Structure
REQ-026 A shared package SHALL hold the FSM state encoding, the register-address width (3), the data width (16) and the timeout limit (15).
REQ-027 Forward lookup SHALL be one sub-module, fwd_lookup, instantiated once per operand port.
REQ-028 Everything else SHALL be flat in stage3_writeback_forward.

Verification
REQ-029 ALU result dest=2, data=16'h1234, then OD1Read with OD1Addr=2 -> Fwd1Valid=1, Fwd1Data=16'h1234; WbValid=1 for one cycle with WbDest=2.
REQ-030 Two ALU results to dest=5 (16'h0001, then 16'h0002), then read addr 5 -> Fwd data is 16'h0002 (E0 priority).
REQ-031 Load to dest=3, OD2Read with OD2Addr=3 -> Stall=1 and Busy=1; MemReady with MemData=16'hBEEF 4 cycles later -> Stall=0, Fwd2Data=16'hBEEF, WbData=16'hBEEF.
REQ-032 Load with no MemReady for 15 cycles -> MemTimeout=1, return to IDLE, WbData=0, Busy=0.
REQ-033 MemReady and ResultValid in the same WAIT_MEM cycle -> only the load data is written back; ResultData is discarded.
REQ-034 rst asserted mid-WAIT_MEM -> next cycle Busy=0, no WbValid, Fwd1Valid=0 and Fwd2Valid=0 for all addresses.

Source files
------------

// File: rtl/stage3_writeback_forward_pkg.sv
// Shared widths, FSM encoding and load-timeout limit for the stage-3 writeback/forward block.
package stage3_writeback_forward_pkg;

  localparam int unsigned AddrWidth = 3;
  localparam int unsigned DataWidth = 16;
  localparam int unsigned CntWidth  = 4;

  // Cycles spent in WAIT_MEM without MemReady before the load is abandoned.
  localparam logic [CntWidth-1:0] TimeoutLimit = 4'd15;

  typedef enum logic [0:0] {
    StIdle    = 1'b0,
    StWaitMem = 1'b1
  } state_e;

endpackage

// File: rtl/stage3_writeback_forward_fwd_lookup.sv
// Bypass lookup for one stage-2 operand port against the two-entry result history.
module fwd_lookup
  import stage3_writeback_forward_pkg::*;
(
  input  logic                 i_read,
  input  logic [AddrWidth-1:0] i_addr,
  input  logic                 i_e0_valid,
  input  logic [AddrWidth-1:0] i_e0_dest,
  input  logic [DataWidth-1:0] i_e0_data,
  input  logic                 i_e1_valid,
  input  logic [AddrWidth-1:0] i_e1_dest,
  input  logic [DataWidth-1:0] i_e1_data,
  output logic                 o_valid,
  output logic [DataWidth-1:0] o_data
);

  logic w_hit0;
  logic w_hit1;

  assign w_hit0 = i_read && i_e0_valid && (i_e0_dest == i_addr);
  assign w_hit1 = i_read && i_e1_valid && (i_e1_dest == i_addr);

  // Newest entry wins; data is forced to zero when nothing matches.
  always_comb begin
    o_valid = 1'b0;
    o_data  = '0;
    if (w_hit0) begin
      o_valid = 1'b1;
      o_data  = i_e0_data;
    end else if (w_hit1) begin
      o_valid = 1'b1;
      o_data  = i_e1_data;
    end
  end

endmodule

// File: rtl/stage3_writeback_forward.sv
// Stage-3 writeback with a two-entry forwarding history, load wait FSM and load timeout.
module stage3_writeback_forward
  import stage3_writeback_forward_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ResultValid,
  input  logic                 IsLoad,
  input  logic [AddrWidth-1:0] ResultDest,
  input  logic [DataWidth-1:0] ResultData,
  input  logic                 MemReady,
  input  logic [DataWidth-1:0] MemData,
  input  logic                 OD1Read,
  input  logic [AddrWidth-1:0] OD1Addr,
  input  logic                 OD2Read,
  input  logic [AddrWidth-1:0] OD2Addr,
  output logic                 Fwd1Valid,
  output logic [DataWidth-1:0] Fwd1Data,
  output logic                 Fwd2Valid,
  output logic [DataWidth-1:0] Fwd2Data,
  output logic                 Stall,
  output logic                 Busy,
  output logic                 WbValid,
  output logic [AddrWidth-1:0] WbDest,
  output logic [DataWidth-1:0] WbData,
  output logic                 MemTimeout
);

  state_e               r_state;
  logic                 r_e0_valid;
  logic [AddrWidth-1:0] r_e0_dest;
  logic [DataWidth-1:0] r_e0_data;
  logic                 r_e1_valid;
  logic [AddrWidth-1:0] r_e1_dest;
  logic [DataWidth-1:0] r_e1_data;
  logic [AddrWidth-1:0] r_pend_dest;
  logic [CntWidth-1:0]  r_cnt;
  logic                 r_wb_valid;
  logic [AddrWidth-1:0] r_wb_dest;
  logic [DataWidth-1:0] r_wb_data;
  logic                 r_timeout;

  logic                 w_load_e0;
  logic [AddrWidth-1:0] w_new_dest;
  logic [DataWidth-1:0] w_new_data;
  logic                 w_timeout_hit;

  assign w_timeout_hit = (r_cnt == (TimeoutLimit - 4'd1));

  // Decide whether E0 is loaded this cycle and with what; ResultValid is ignored while waiting.
  always_comb begin
    w_load_e0  = 1'b0;
    w_new_dest = ResultDest;
    w_new_data = ResultData;
    unique case (r_state)
      StIdle: begin
        if (ResultValid && !IsLoad) begin
          w_load_e0 = 1'b1;
        end
      end
      StWaitMem: begin
        w_new_dest = r_pend_dest;
        if (MemReady) begin
          w_load_e0  = 1'b1;
          w_new_data = MemData;
        end else if (w_timeout_hit) begin
          w_load_e0  = 1'b1;
          w_new_data = '0;
        end
      end
      default: ;
    endcase
  end

  // FSM, history shift, writeback register and sticky timeout flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= StIdle;
      r_e0_valid  <= 1'b0;
      r_e0_dest   <= '0;
      r_e0_data   <= '0;
      r_e1_valid  <= 1'b0;
      r_e1_dest   <= '0;
      r_e1_data   <= '0;
      r_pend_dest <= '0;
      r_cnt       <= '0;
      r_wb_valid  <= 1'b0;
      r_wb_dest   <= '0;
      r_wb_data   <= '0;
      r_timeout   <= 1'b0;
    end else begin
      r_wb_valid <= 1'b0;
      if (w_load_e0) begin
        r_e1_valid <= r_e0_valid;
        r_e1_dest  <= r_e0_dest;
        r_e1_data  <= r_e0_data;
        r_e0_valid <= 1'b1;
        r_e0_dest  <= w_new_dest;
        r_e0_data  <= w_new_data;
        r_wb_valid <= 1'b1;
        r_wb_dest  <= w_new_dest;
        r_wb_data  <= w_new_data;
      end
      unique case (r_state)
        StIdle: begin
          // Existing entries for the same dest stay valid; Stall covers the hazard.
          if (ResultValid && IsLoad) begin
            r_pend_dest <= ResultDest;
            r_cnt       <= '0;
            r_state     <= StWaitMem;
          end
        end
        StWaitMem: begin
          if (MemReady) begin
            r_state <= StIdle;
          end else begin
            r_cnt <= r_cnt + 4'd1;
            if (w_timeout_hit) begin
              r_timeout <= 1'b1;
              r_state   <= StIdle;
            end
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  fwd_lookup u_fwd1 (
    .i_read    (OD1Read),
    .i_addr    (OD1Addr),
    .i_e0_valid(r_e0_valid),
    .i_e0_dest (r_e0_dest),
    .i_e0_data (r_e0_data),
    .i_e1_valid(r_e1_valid),
    .i_e1_dest (r_e1_dest),
    .i_e1_data (r_e1_data),
    .o_valid   (Fwd1Valid),
    .o_data    (Fwd1Data)
  );

  fwd_lookup u_fwd2 (
    .i_read    (OD2Read),
    .i_addr    (OD2Addr),
    .i_e0_valid(r_e0_valid),
    .i_e0_dest (r_e0_dest),
    .i_e0_data (r_e0_data),
    .i_e1_valid(r_e1_valid),
    .i_e1_dest (r_e1_dest),
    .i_e1_data (r_e1_data),
    .o_valid   (Fwd2Valid),
    .o_data    (Fwd2Data)
  );

  assign Stall = (r_state == StWaitMem) &&
                 ((OD1Read && (OD1Addr == r_pend_dest)) || (OD2Read && (OD2Addr == r_pend_dest)));
  assign Busy       = (r_state == StWaitMem);
  assign WbValid    = r_wb_valid;
  assign WbDest     = r_wb_dest;
  assign WbData     = r_wb_data;
  assign MemTimeout = r_timeout;

endmodule

// File: tb/tb_stage3_writeback_forward.sv
// Directed self-checking bench for stage3_writeback_forward.
module tb_stage3_writeback_forward;

  logic        clk;
  logic        rst;
  logic        ResultValid;
  logic        IsLoad;
  logic [2:0]  ResultDest;
  logic [15:0] ResultData;
  logic        MemReady;
  logic [15:0] MemData;
  logic        OD1Read;
  logic [2:0]  OD1Addr;
  logic        OD2Read;
  logic [2:0]  OD2Addr;
  logic        Fwd1Valid;
  logic [15:0] Fwd1Data;
  logic        Fwd2Valid;
  logic [15:0] Fwd2Data;
  logic        Stall;
  logic        Busy;
  logic        WbValid;
  logic [2:0]  WbDest;
  logic [15:0] WbData;
  logic        MemTimeout;

  int checks;
  int errors;

  stage3_writeback_forward dut (
    .clk        (clk),
    .rst        (rst),
    .ResultValid(ResultValid),
    .IsLoad     (IsLoad),
    .ResultDest (ResultDest),
    .ResultData (ResultData),
    .MemReady   (MemReady),
    .MemData    (MemData),
    .OD1Read    (OD1Read),
    .OD1Addr    (OD1Addr),
    .OD2Read    (OD2Read),
    .OD2Addr    (OD2Addr),
    .Fwd1Valid  (Fwd1Valid),
    .Fwd1Data   (Fwd1Data),
    .Fwd2Valid  (Fwd2Valid),
    .Fwd2Data   (Fwd2Data),
    .Stall      (Stall),
    .Busy       (Busy),
    .WbValid    (WbValid),
    .WbDest     (WbDest),
    .WbData     (WbData),
    .MemTimeout (MemTimeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge; inputs change and outputs are sampled 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ResultValid = 1'b0;
    IsLoad      = 1'b0;
    ResultDest  = 3'd0;
    ResultData  = 16'h0;
    MemReady    = 1'b0;
    MemData     = 16'h0;
  endtask

  task automatic alu_write(input logic [2:0] dest, input logic [15:0] data);
    ResultValid = 1'b1;
    IsLoad      = 1'b0;
    ResultDest  = dest;
    ResultData  = data;
    tick();
    idle_inputs();
  endtask

  task automatic issue_load(input logic [2:0] dest);
    ResultValid = 1'b1;
    IsLoad      = 1'b1;
    ResultDest  = dest;
    ResultData  = 16'hDEAD;
    tick();
    idle_inputs();
  endtask

  task automatic test_reset();
    idle_inputs();
    OD1Read = 1'b1; OD1Addr = 3'd0;
    OD2Read = 1'b1; OD2Addr = 3'd0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if ({Busy, Stall, WbValid, MemTimeout} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags: got busy/stall/wb/to=%b required 0000",
               {Busy, Stall, WbValid, MemTimeout});
    end
    checks++;
    if (WbDest !== 3'd0 || WbData !== 16'h0) begin
      errors++;
      $display("FAIL reset_wb: got dest=%0d data=%h required 0/0000", WbDest, WbData);
    end
    checks++;
    if ({Fwd1Valid, Fwd2Valid} !== 2'b00 || Fwd1Data !== 16'h0 || Fwd2Data !== 16'h0) begin
      errors++;
      $display("FAIL reset_fwd: got v=%b d1=%h d2=%h required 00/0000/0000",
               {Fwd1Valid, Fwd2Valid}, Fwd1Data, Fwd2Data);
    end
    OD1Read = 1'b0;
    OD2Read = 1'b0;
  endtask

  task automatic test_alu_forward();
    alu_write(3'd2, 16'h1234);
    checks++;
    if (WbValid !== 1'b1 || WbDest !== 3'd2 || WbData !== 16'h1234) begin
      errors++;
      $display("FAIL alu_wb: got v=%b dest=%0d data=%h required 1/2/1234", WbValid, WbDest, WbData);
    end
    OD1Read = 1'b1; OD1Addr = 3'd2;
    #1;
    checks++;
    if (Fwd1Valid !== 1'b1 || Fwd1Data !== 16'h1234) begin
      errors++;
      $display("FAIL alu_fwd1: got v=%b data=%h required 1/1234", Fwd1Valid, Fwd1Data);
    end
    OD1Addr = 3'd4;
    #1;
    checks++;
    if (Fwd1Valid !== 1'b0 || Fwd1Data !== 16'h0) begin
      errors++;
      $display("FAIL alu_fwd_miss: got v=%b data=%h required 0/0000", Fwd1Valid, Fwd1Data);
    end
    OD1Read = 1'b0;
    tick();
    checks++;
    if (WbValid !== 1'b0) begin
      errors++;
      $display("FAIL alu_wb_pulse: got WbValid=%b required 0", WbValid);
    end
  endtask

  task automatic test_e0_priority();
    alu_write(3'd5, 16'h0001);
    alu_write(3'd5, 16'h0002);
    OD1Read = 1'b1; OD1Addr = 3'd5;
    OD2Read = 1'b1; OD2Addr = 3'd5;
    #1;
    checks++;
    if (Fwd1Valid !== 1'b1 || Fwd1Data !== 16'h0002 || Fwd2Valid !== 1'b1 ||
        Fwd2Data !== 16'h0002) begin
      errors++;
      $display("FAIL e0_priority: got v1=%b d1=%h v2=%b d2=%h required 1/0002/1/0002",
               Fwd1Valid, Fwd1Data, Fwd2Valid, Fwd2Data);
    end
    OD1Read = 1'b0;
    OD2Read = 1'b0;
  endtask

  task automatic test_load_stall();
    issue_load(3'd3);
    OD2Read = 1'b1; OD2Addr = 3'd3;
    #1;
    checks++;
    if (Stall !== 1'b1 || Busy !== 1'b1 || Fwd2Valid !== 1'b0) begin
      errors++;
      $display("FAIL load_stall: got stall=%b busy=%b fwd2v=%b required 1/1/0",
               Stall, Busy, Fwd2Valid);
    end
    OD2Addr = 3'd4;
    #1;
    checks++;
    if (Stall !== 1'b0) begin
      errors++;
      $display("FAIL load_no_stall_other: got stall=%b required 0", Stall);
    end
    OD2Addr = 3'd3;
    tick();
    tick();
    tick();
    MemReady = 1'b1; MemData = 16'hBEEF;
    tick();
    idle_inputs();
    checks++;
    if (Stall !== 1'b0 || Busy !== 1'b0 || Fwd2Valid !== 1'b1 || Fwd2Data !== 16'hBEEF) begin
      errors++;
      $display("FAIL load_done: got stall=%b busy=%b v=%b data=%h required 0/0/1/beef",
               Stall, Busy, Fwd2Valid, Fwd2Data);
    end
    checks++;
    if (WbValid !== 1'b1 || WbDest !== 3'd3 || WbData !== 16'hBEEF) begin
      errors++;
      $display("FAIL load_wb: got v=%b dest=%0d data=%h required 1/3/beef", WbValid, WbDest, WbData);
    end
    OD2Read = 1'b0;
  endtask

  task automatic test_timeout();
    issue_load(3'd6);
    for (int i = 0; i < 14; i++) tick();
    checks++;
    if (Busy !== 1'b1 || MemTimeout !== 1'b0 || WbValid !== 1'b0) begin
      errors++;
      $display("FAIL timeout_early: got busy=%b to=%b wb=%b required 1/0/0", Busy, MemTimeout, WbValid);
    end
    tick();
    checks++;
    if (MemTimeout !== 1'b1 || Busy !== 1'b0) begin
      errors++;
      $display("FAIL timeout_flag: got to=%b busy=%b required 1/0", MemTimeout, Busy);
    end
    checks++;
    if (WbValid !== 1'b1 || WbDest !== 3'd6 || WbData !== 16'h0) begin
      errors++;
      $display("FAIL timeout_wb: got v=%b dest=%0d data=%h required 1/6/0000", WbValid, WbDest, WbData);
    end
    OD1Read = 1'b1; OD1Addr = 3'd6;
    tick();
    tick();
    checks++;
    if (MemTimeout !== 1'b1 || Fwd1Valid !== 1'b1 || Fwd1Data !== 16'h0) begin
      errors++;
      $display("FAIL timeout_sticky: got to=%b v=%b data=%h required 1/1/0000",
               MemTimeout, Fwd1Valid, Fwd1Data);
    end
    OD1Read = 1'b0;
  endtask

  task automatic test_mem_and_result();
    issue_load(3'd1);
    MemReady    = 1'b1; MemData = 16'hCAFE;
    ResultValid = 1'b1; IsLoad = 1'b0; ResultDest = 3'd7; ResultData = 16'h5555;
    tick();
    idle_inputs();
    checks++;
    if (WbValid !== 1'b1 || WbDest !== 3'd1 || WbData !== 16'hCAFE) begin
      errors++;
      $display("FAIL collide_wb: got v=%b dest=%0d data=%h required 1/1/cafe", WbValid, WbDest, WbData);
    end
    OD1Read = 1'b1; OD1Addr = 3'd7;
    tick();
    checks++;
    if (Fwd1Valid !== 1'b0 || WbValid !== 1'b0) begin
      errors++;
      $display("FAIL collide_discard: got fwd1v=%b wb=%b required 0/0", Fwd1Valid, WbValid);
    end
    OD1Read = 1'b0;
  endtask

  task automatic test_load_same_dest();
    issue_load(3'd1);
    OD1Read = 1'b1; OD1Addr = 3'd1;
    #1;
    checks++;
    if (Stall !== 1'b1 || Fwd1Valid !== 1'b1 || Fwd1Data !== 16'hCAFE) begin
      errors++;
      $display("FAIL same_dest_keep: got stall=%b v=%b data=%h required 1/1/cafe",
               Stall, Fwd1Valid, Fwd1Data);
    end
    MemReady = 1'b1; MemData = 16'h4444;
    tick();
    idle_inputs();
    checks++;
    if (Stall !== 1'b0 || Fwd1Data !== 16'h4444) begin
      errors++;
      $display("FAIL same_dest_done: got stall=%b data=%h required 0/4444", Stall, Fwd1Data);
    end
    OD1Read = 1'b0;
  endtask

  task automatic test_reset_mid_wait();
    issue_load(3'd2);
    rst = 1'b1;
    MemReady = 1'b1; MemData = 16'h1111;
    tick();
    rst = 1'b0;
    idle_inputs();
    checks++;
    if (Busy !== 1'b0 || WbValid !== 1'b0 || MemTimeout !== 1'b0) begin
      errors++;
      $display("FAIL rst_wait_flags: got busy=%b wb=%b to=%b required 0/0/0", Busy, WbValid, MemTimeout);
    end
    OD1Read = 1'b1;
    OD2Read = 1'b1;
    for (int a = 0; a < 8; a++) begin
      OD1Addr = a[2:0];
      OD2Addr = a[2:0];
      #1;
      checks++;
      if (Fwd1Valid !== 1'b0 || Fwd2Valid !== 1'b0 || Fwd1Data !== 16'h0 || Fwd2Data !== 16'h0) begin
        errors++;
        $display("FAIL rst_wait_fwd addr=%0d: got v1=%b v2=%b d1=%h d2=%h required 0/0/0000/0000",
                 a, Fwd1Valid, Fwd2Valid, Fwd1Data, Fwd2Data);
      end
    end
    tick();
    checks++;
    if (WbValid !== 1'b0 || Busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_wait_dropped: got wb=%b busy=%b required 0/0", WbValid, Busy);
    end
    OD1Read = 1'b0;
    OD2Read = 1'b0;
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    rst     = 1'b1;
    OD1Read = 1'b0; OD1Addr = 3'd0;
    OD2Read = 1'b0; OD2Addr = 3'd0;
    idle_inputs();
    test_reset();
    test_alu_forward();
    test_e0_priority();
    test_load_stall();
    test_timeout();
    test_mem_and_result();
    test_load_same_dest();
    test_reset_mid_wait();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
